vend_change_dispenser: RTL

//  Change-return controller for retro_vending. After a vend, the vending FSM requests change for a cents amount.

---
 rtl/vend_change_dispenser_if.sv | 33 +++
 rtl/vend_change_dispenser.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vend_change_dispenser_if.sv
// Change request, coin hopper eject handshake, restock and inventory signals
// shared between the vending controller, the hopper and the change dispenser.
interface vend_change_dispenser_if #(
  parameter int unsigned AMT_W = 8,
  parameter int unsigned CNT_W = 6
);
  logic             change_req;
  logic [AMT_W-1:0] change_amt;
  logic             busy;
  logic             done;
  logic             short_pay;
  logic             fault;
  logic [AMT_W-1:0] shortfall;
  logic             eject_valid;
  logic [1:0]       eject_coin;
  logic             eject_ack;
  logic             restock_valid;
  logic [1:0]       restock_coin;
  logic [CNT_W-1:0] restock_qty;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_n;

  modport master (
    output change_req, change_amt, eject_ack, restock_valid, restock_coin, restock_qty,
    input  busy, done, short_pay, fault, shortfall, eject_valid, eject_coin, cnt_q, cnt_d, cnt_n
  );

  modport slave (
    input  change_req, change_amt, eject_ack, restock_valid, restock_coin, restock_qty,
    output busy, done, short_pay, fault, shortfall, eject_valid, eject_coin, cnt_q, cnt_d, cnt_n
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// Change-return controller: pays out change greedily (25/10/5) through a coin
// hopper valid/ack handshake while tracking and restocking coin inventory.
module vend_change_dispenser #(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned INIT_Q      = 20,
  parameter int unsigned INIT_D      = 20,
  parameter int unsigned INIT_N      = 20,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  vend_change_dispenser_if.slave bus
);

  localparam int unsigned    TMR_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [1:0]     COIN_NONE = 2'd0;
  localparam logic [1:0]     COIN_N    = 2'd1;
  localparam logic [1:0]     COIN_D    = 2'd2;
  localparam logic [1:0]     COIN_Q    = 2'd3;

  typedef enum logic [1:0] {IDLE, PICK, EJECT, DONE} state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] frac_q, frac_d;
  logic [1:0]       coin_q, coin_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;
  logic [1:0]       dec_coin;

  logic             busy_r, done_r, short_r, fault_r, ev_r;
  logic [1:0]       ecoin_r;
  logic [AMT_W-1:0] sf_r;
  logic             busy_d, done_d, short_d, fault_d, ev_d;
  logic [1:0]       ecoin_d;
  logic [AMT_W-1:0] sf_d;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_Q:  return AMT_W'(25);
      COIN_D:  return AMT_W'(10);
      COIN_N:  return AMT_W'(5);
      default: return '0;
    endcase
  endfunction

  // Saturating add of a restock plus optional decrement from an accepted eject.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic add,
                                                input logic [CNT_W-1:0] qty, input logic sub);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (add ? {1'b0, qty} : '0) - (CNT_W+1)'(sub);
    return (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    frac_d   = frac_q;
    coin_d   = coin_q;
    timer_d  = timer_q;
    dec_coin = COIN_NONE;
    fault_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.change_req) begin
          frac_d  = bus.change_amt % AMT_W'(5);
          rem_d   = bus.change_amt - frac_d;
          state_d = PICK;
        end
      end
      PICK: begin
        timer_d = '0;
        state_d = EJECT;
        if (rem_q >= coin_value(COIN_Q) && q_cnt != '0) begin
          coin_d = COIN_Q;
        end else if (rem_q >= coin_value(COIN_D) && d_cnt != '0) begin
          coin_d = COIN_D;
        end else if (rem_q >= coin_value(COIN_N) && n_cnt != '0) begin
          coin_d = COIN_N;
        end else begin
          state_d = DONE;
        end
      end
      EJECT: begin
        if (bus.eject_ack) begin
          dec_coin = coin_q;
          rem_d    = rem_q - coin_value(coin_q);
          timer_d  = '0;
          state_d  = PICK;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          fault_d  = 1'b1;
          state_d  = DONE;
        end else begin
          timer_d  = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    sf_d    = done_d ? (rem_d + frac_d) : '0;
    short_d = done_d && (sf_d != '0);
    ev_d    = (state_d == EJECT);
    ecoin_d = ev_d ? coin_d : COIN_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      frac_q  <= '0;
      coin_q  <= COIN_NONE;
      timer_q <= '0;
      q_cnt   <= CNT_W'(INIT_Q);
      d_cnt   <= CNT_W'(INIT_D);
      n_cnt   <= CNT_W'(INIT_N);
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      short_r <= 1'b0;
      fault_r <= 1'b0;
      sf_r    <= '0;
      ev_r    <= 1'b0;
      ecoin_r <= COIN_NONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      frac_q  <= frac_d;
      coin_q  <= coin_d;
      timer_q <= timer_d;
      q_cnt   <= cnt_next(q_cnt, bus.restock_valid && bus.restock_coin == COIN_Q,
                          bus.restock_qty, dec_coin == COIN_Q);
      d_cnt   <= cnt_next(d_cnt, bus.restock_valid && bus.restock_coin == COIN_D,
                          bus.restock_qty, dec_coin == COIN_D);
      n_cnt   <= cnt_next(n_cnt, bus.restock_valid && bus.restock_coin == COIN_N,
                          bus.restock_qty, dec_coin == COIN_N);
      busy_r  <= busy_d;
      done_r  <= done_d;
      short_r <= short_d;
      fault_r <= fault_d;
      sf_r    <= sf_d;
      ev_r    <= ev_d;
      ecoin_r <= ecoin_d;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.short_pay   = short_r;
  assign bus.fault       = fault_r;
  assign bus.shortfall   = sf_r;
  assign bus.eject_valid = ev_r;
  assign bus.eject_coin  = ecoin_r;
  assign bus.cnt_q       = q_cnt;
  assign bus.cnt_d       = d_cnt;
  assign bus.cnt_n       = n_cnt;

endmodule
